cl1_bus_arbiter: RTL and testbench

- Shared-bus arbiter answering the L1 cache control units' bus requests (bus_req / bus_req_op / bus_req_clc) with one-hot bus_get grants.
- Write-back (WR) requests take priority over read-miss (RD) address requests; round-robin within each class.
- Each grant is held for the number of cycles the requester asked for, then released after a fixed turnaround.
- Sits between the per-core cacheL1_control_unit instances and the bus interface / memory side.

---
 rtl/cl1_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cl1_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cl1_bus_arbiter.sv
// Shared-bus arbiter for the L1 cache control units: write-backs beat read-miss requests,
// round-robin within each class, grant held for the requested tenure then one turnaround cycle.
module cl1_bus_arbiter #(
    parameter int N_REQ = 4,
    parameter int OWN_W = 2,
    parameter int CLC_W = 4
) (
    input  logic                     plusclk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         bus_req,
    input  logic [N_REQ-1:0]         bus_req_op,
    input  logic [N_REQ*CLC_W-1:0]   bus_req_clc,
    output logic [N_REQ-1:0]         bus_get,
    output logic                     bus_busy,
    output logic [OWN_W-1:0]         bus_owner,
    output logic                     bus_op,
    output logic [CLC_W-1:0]         tenure_left
);

    localparam int unsigned N_REQ_U = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_get;
    logic [N_REQ-1:0]   w_get_nxt;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   w_owner_nxt;
    logic               r_op;
    logic               w_op_nxt;
    logic [CLC_W-1:0]   r_tenure;
    logic [CLC_W-1:0]   w_tenure_nxt;
    logic [OWN_W-1:0]   r_ptr_rd;
    logic [OWN_W-1:0]   w_ptr_rd_nxt;
    logic [OWN_W-1:0]   r_ptr_wr;
    logic [OWN_W-1:0]   w_ptr_wr_nxt;

    logic [OWN_W:0]     w_wr_pick;
    logic [OWN_W:0]     w_rd_pick;
    logic               w_any;
    logic [OWN_W-1:0]   w_win;
    logic [CLC_W-1:0]   w_win_clc;
    logic [CLC_W-1:0]   w_win_len;
    logic               w_release;

    // (a + off) mod N_REQ, with a < N_REQ and off < N_REQ
    function automatic logic [OWN_W-1:0] f_wrap_inc(input logic [OWN_W-1:0] a,
                                                    input int unsigned     off);
        int unsigned s;
        s = 32'(a) + off;
        if (s >= N_REQ_U) begin
            s = s - N_REQ_U;
        end
        return s[OWN_W-1:0];
    endfunction

    // Returns {found, index} of the first set bit of mask at or after ptr, wrapping.
    function automatic logic [OWN_W:0] f_rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [OWN_W-1:0] ptr);
        logic [OWN_W-1:0] cand;
        logic [OWN_W:0]   res;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = f_wrap_inc(ptr, unsigned'(i));
            if (mask[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign w_wr_pick = f_rr_pick(bus_req & bus_req_op, r_ptr_wr);
    assign w_rd_pick = f_rr_pick(bus_req, r_ptr_rd);
    assign w_any     = w_rd_pick[OWN_W];
    assign w_win     = w_wr_pick[OWN_W] ? w_wr_pick[OWN_W-1:0] : w_rd_pick[OWN_W-1:0];

    always_comb begin
        w_win_clc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == OWN_W'(i)) begin
                w_win_clc = bus_req_clc[i*CLC_W +: CLC_W];
            end
        end
    end

    // A zero-length request still gets one bus cycle.
    assign w_win_len = (w_win_clc == '0) ? CLC_W'(1) : w_win_clc;
    assign w_release = (r_tenure == CLC_W'(1)) || !bus_req[r_owner];

    always_comb begin
        w_state_nxt  = r_state;
        w_get_nxt    = r_get;
        w_owner_nxt  = r_owner;
        w_op_nxt     = r_op;
        w_tenure_nxt = r_tenure;
        w_ptr_rd_nxt = r_ptr_rd;
        w_ptr_wr_nxt = r_ptr_wr;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_get_nxt    = N_REQ'(1) << w_win;
                    w_owner_nxt  = w_win;
                    w_op_nxt     = bus_req_op[w_win];
                    w_tenure_nxt = w_win_len;
                    w_state_nxt  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_get_nxt    = '0;
                    w_tenure_nxt = '0;
                    w_state_nxt  = ST_TURN;
                    if (r_op) begin
                        w_ptr_wr_nxt = f_wrap_inc(r_owner, 32'd1);
                    end else begin
                        w_ptr_rd_nxt = f_wrap_inc(r_owner, 32'd1);
                    end
                end else begin
                    w_tenure_nxt = r_tenure - CLC_W'(1);
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_get_nxt    = '0;
                w_tenure_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge plusclk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_get    <= '0;
            r_owner  <= '0;
            r_op     <= 1'b0;
            r_tenure <= '0;
            r_ptr_rd <= '0;
            r_ptr_wr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_get    <= w_get_nxt;
            r_owner  <= w_owner_nxt;
            r_op     <= w_op_nxt;
            r_tenure <= w_tenure_nxt;
            r_ptr_rd <= w_ptr_rd_nxt;
            r_ptr_wr <= w_ptr_wr_nxt;
        end
    end

    assign bus_get     = r_get;
    assign bus_busy    = |r_get;
    assign bus_owner   = r_owner;
    assign bus_op      = r_op;
    assign tenure_left = r_tenure;

endmodule

// File: tb/tb_cl1_bus_arbiter.sv
// Bench for cl1_bus_arbiter: directed reset/priority scenarios, then random requesters
// scored against a transaction-level model of the arbitration rules.
module tb_cl1_bus_arbiter;

    localparam int N_REQ = 4;
    localparam int OWN_W = 2;
    localparam int CLC_W = 4;

    logic                   plusclk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       bus_req = '0;
    logic [N_REQ-1:0]       bus_req_op = '0;
    logic [N_REQ*CLC_W-1:0] bus_req_clc = '0;
    logic [N_REQ-1:0]       bus_get;
    logic                   bus_busy;
    logic [OWN_W-1:0]       bus_owner;
    logic                   bus_op;
    logic [CLC_W-1:0]       tenure_left;

    cl1_bus_arbiter #(.N_REQ(N_REQ), .OWN_W(OWN_W), .CLC_W(CLC_W)) dut (
        .plusclk     (plusclk),
        .rst         (rst),
        .bus_req     (bus_req),
        .bus_req_op  (bus_req_op),
        .bus_req_clc (bus_req_clc),
        .bus_get     (bus_get),
        .bus_busy    (bus_busy),
        .bus_owner   (bus_owner),
        .bus_op      (bus_op),
        .tenure_left (tenure_left)
    );

    always #5 plusclk = ~plusclk;

    int cyc = 0;
    always @(posedge plusclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Negative expectation means "don't care".
    task automatic expect_out(input string tag, input int g, input int b, input int o,
                              input int p, input int t);
        if (g >= 0) chk({tag, "_get"}, int'(bus_get), g);
        if (b >= 0) chk({tag, "_busy"}, int'(bus_busy), b);
        if (o >= 0) chk({tag, "_owner"}, int'(bus_owner), o);
        if (p >= 0) chk({tag, "_op"}, int'(bus_op), p);
        if (t >= 0) chk({tag, "_tenure"}, int'(tenure_left), t);
    endtask

    task automatic tick();
        @(posedge plusclk);
        #1;
    endtask

    // Scoreboard: one entry per expected grant.
    typedef struct {
        int start;
        int owner;
        int op;
        int clc_eff;
        int len;
    } grant_t;

    grant_t exp_q[$];
    bit     mon_en = 1'b0;
    bit     m_active = 1'b0;
    grant_t m_cur;
    int     m_held = 0;

    always @(negedge plusclk) begin
        if (mon_en) begin
            chk("busy_vs_get", int'(bus_busy), int'(bus_get != '0));
            chk("get_onehot0", int'($onehot0(bus_get)), 1);
            if (bus_busy && !m_active) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant_qsize", exp_q.size(), 1);
                    m_cur = '{cyc, int'(bus_owner), int'(bus_op), int'(tenure_left), 0};
                end else begin
                    m_cur = exp_q.pop_front();
                    chk("grant_start_cycle", cyc, m_cur.start);
                end
                m_active = 1'b1;
                m_held   = 0;
            end
            if (m_active) begin
                if (bus_busy) begin
                    chk("grant_get", int'(bus_get), 1 << m_cur.owner);
                    chk("grant_owner", int'(bus_owner), m_cur.owner);
                    chk("grant_op", int'(bus_op), m_cur.op);
                    chk("grant_tenure", int'(tenure_left), m_cur.clc_eff - m_held);
                    m_held++;
                end else begin
                    chk("tenure_len", m_held, m_cur.len);
                    chk("release_tenure", int'(tenure_left), 0);
                    chk("owner_hold", int'(bus_owner), m_cur.owner);
                    m_active = 1'b0;
                end
            end
        end
    end

    // Random requester agents plus the arbitration model.
    int st[N_REQ];       // 0 = not requesting, 1 = waiting, 2 = granted
    int cool[N_REQ];
    int op_r[N_REQ];
    int clc_r[N_REQ];
    int hold[N_REQ];     // grant cycles the requester keeps bus_req high before dropping
    int drop_at[N_REQ];
    int ptr_rd, ptr_wr, free_at;

    task automatic step(input bit allow_new);
        int  k, ptr, ce, len;
        bit  any_wr;
        @(posedge plusclk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (st[i] == 2 && cyc == drop_at[i]) begin
                st[i]   = 0;
                cool[i] = $urandom_range(0, 3);
            end else if (st[i] == 0) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if (allow_new && $urandom_range(0, 2) == 0) begin
                    st[i]    = 1;
                    op_r[i]  = ($urandom_range(0, 2) == 0) ? 1 : 0;
                    clc_r[i] = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5);
                    hold[i]  = $urandom_range(0, 7);
                end
            end
            if ($urandom_range(0, 4) == 0) clc_r[i] = $urandom_range(0, 6);
            bus_req[i]    = (st[i] != 0);
            bus_req_op[i] = (op_r[i] != 0);
            bus_req_clc[i*CLC_W +: CLC_W] = CLC_W'(clc_r[i]);
        end
        if (cyc >= free_at) begin
            any_wr = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (st[i] == 1 && op_r[i] != 0) any_wr = 1'b1;
            end
            ptr = any_wr ? ptr_wr : ptr_rd;
            k   = -1;
            for (int j = 0; j < N_REQ; j++) begin
                int idx;
                idx = (ptr + j) % N_REQ;
                if (k < 0 && st[idx] == 1 && (!any_wr || op_r[idx] != 0)) k = idx;
            end
            if (k >= 0) begin
                ce  = (clc_r[k] == 0) ? 1 : clc_r[k];
                len = (hold[k] + 1 < ce) ? hold[k] + 1 : ce;
                exp_q.push_back('{cyc + 1, k, op_r[k], ce, len});
                if (any_wr) ptr_wr = (k + 1) % N_REQ;
                else        ptr_rd = (k + 1) % N_REQ;
                drop_at[k] = cyc + 1 + ((hold[k] < len) ? hold[k] : len);
                st[k]      = 2;
                free_at    = cyc + len + 2;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit all_quiet;
        #1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0);

        // Single read-miss, two-cycle tenure.
        bus_req = 4'b0001;
        bus_req_op = 4'b0000;
        bus_req_clc[0*CLC_W +: CLC_W] = 4'd2;
        tick(); expect_out("rd_g1", 1, 1, 0, 0, 2);
        tick(); expect_out("rd_g2", 1, 1, 0, 0, 1);
        bus_req = 4'b0000;
        tick(); expect_out("rd_turn", 0, 0, 0, -1, 0);
        tick(); expect_out("rd_idle", 0, 0, 0, -1, 0);

        // Write-back beats a concurrent read-miss.
        bus_req    = 4'b0011;
        bus_req_op = 4'b0010;
        bus_req_clc[0*CLC_W +: CLC_W] = 4'd1;
        bus_req_clc[1*CLC_W +: CLC_W] = 4'd2;
        tick(); expect_out("wr_g1", 2, 1, 1, 1, 2);
        tick(); expect_out("wr_g2", 2, 1, 1, 1, 1);
        bus_req = 4'b0001;
        tick(); expect_out("wr_turn", 0, 0, 1, -1, 0);
        tick(); expect_out("wr_idle", 0, 0, 1, -1, 0);
        tick(); expect_out("rd0_g1", 1, 1, 0, 0, 1);
        bus_req = 4'b0000;
        tick(); expect_out("rd0_rel", 0, 0, 0, -1, 0);
        tick();
        tick();

        // Reset during the second cycle of a four-cycle write-back tenure.
        bus_req    = 4'b0100;
        bus_req_op = 4'b0100;
        bus_req_clc[2*CLC_W +: CLC_W] = 4'd4;
        tick(); expect_out("rm_g1", 4, 1, 2, 1, 4);
        tick(); expect_out("rm_g2", 4, 1, 2, 1, 3);
        rst = 1'b1;
        tick(); expect_out("rm_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(); expect_out("rm_regrant", 4, 1, 2, 1, 4);
        bus_req = 4'b0000;
        tick(); expect_out("rm_early_rel", 0, 0, 2, -1, 0);

        // Clean reset, then random traffic against the model.
        bus_req = '0;
        bus_req_op = '0;
        bus_req_clc = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            st[i] = 0; cool[i] = 0; op_r[i] = 0; clc_r[i] = 0; hold[i] = 0; drop_at[i] = 0;
        end
        ptr_rd   = 0;
        ptr_wr   = 0;
        free_at  = cyc;
        exp_q.delete();
        m_active = 1'b0;
        mon_en   = 1'b1;

        for (int n = 0; n < 3000; n++) step(1'b1);

        for (int t = 0; t < 400; t++) begin
            all_quiet = 1'b1;
            for (int i = 0; i < N_REQ; i++) if (st[i] != 0) all_quiet = 1'b0;
            if (all_quiet && exp_q.size() == 0 && !m_active && !bus_busy) break;
            step(1'b0);
        end
        tick();
        tick();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_bus_idle", int'(bus_busy), 0);
        chk("drain_tenure_zero", int'(tenure_left), 0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
